// File: rtl/adder_pkg.sv
// Shared definitions for the adder's downstream consumers: sum width, window FSM
// states and the accumulator width derivation.
package adder_pkg;

    localparam int SUM_W = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Wide enough for COUNT samples of full-scale value without overflow.
    function automatic int acc_width(input int sum_w, input int count);
        return sum_w + $clog2(count);
    endfunction

endpackage

// File: rtl/sum_window_accumulator_sample_counter.sv
// Per-window sample counter: clears on window close, counts accepted beats and
// flags when the next accepted beat completes a full window.
module sample_counter #(
    parameter int COUNT = 8,
    parameter int CNT_W = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_r;

    // Counter register; clear together with inc restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear && inc) begin
            cnt_r <= CNT_W'(1);
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign last = (cnt_r == CNT_W'(COUNT - 1));

endmodule

// File: rtl/sum_window_accumulator.sv
// Windowed accumulator for adder sums: totals, maximum and sample count per window
// of COUNT beats, closed early by flush, handed off over a valid/ready output.
module sum_window_accumulator
    import adder_pkg::*;
#(
    parameter int COUNT = 8,
    parameter int CNT_W = $clog2(COUNT + 1),
    parameter int ACC_W = acc_width(SUM_W, COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] S,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [SUM_W-1:0] out_max,
    output logic [CNT_W-1:0] out_count
);

    state_e           state_r;
    state_e           state_n_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_n_s;
    logic [SUM_W-1:0] max_r;
    logic [SUM_W-1:0] max_n_s;
    logic [ACC_W-1:0] out_total_r;
    logic [SUM_W-1:0] out_max_r;
    logic [CNT_W-1:0] out_count_r;

    logic [CNT_W-1:0] cnt_s;
    logic             last_s;
    logic             cnt_clr_s;
    logic             cnt_inc_s;
    logic             load_out_s;

    logic             in_ready_s;
    logic             accept_s;
    logic             close_s;
    logic [ACC_W-1:0] s_ext_s;
    logic [ACC_W-1:0] beat_acc_s;
    logic [SUM_W-1:0] beat_max_s;
    logic [CNT_W-1:0] beat_cnt_s;

    sample_counter #(
        .COUNT (COUNT),
        .CNT_W (CNT_W)
    ) u_sample_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clr_s),
        .inc   (cnt_inc_s),
        .cnt   (cnt_s),
        .last  (last_s)
    );

    // In HOLD the input is gated by the output handshake so a take and a new beat share a cycle.
    assign in_ready_s = (state_r == ACCUM) || out_ready;
    assign accept_s   = in_valid && in_ready_s;
    assign s_ext_s    = {{(ACC_W - SUM_W){1'b0}}, S};
    assign beat_acc_s = accept_s ? (acc_r + s_ext_s) : acc_r;
    assign beat_max_s = (accept_s && (S > max_r)) ? S : max_r;
    assign beat_cnt_s = accept_s ? (cnt_s + CNT_W'(1)) : cnt_s;
    assign close_s    = (state_r == ACCUM) &&
                        ((accept_s && last_s) || (flush && ((cnt_s != {CNT_W{1'b0}}) || accept_s)));

    // Next-state and datapath control for the ACCUM/HOLD window FSM.
    always_comb begin
        state_n_s  = state_r;
        acc_n_s    = acc_r;
        max_n_s    = max_r;
        cnt_clr_s  = 1'b0;
        cnt_inc_s  = 1'b0;
        load_out_s = 1'b0;
        case (state_r)
            ACCUM: begin
                if (close_s) begin
                    load_out_s = 1'b1;
                    cnt_clr_s  = 1'b1;
                    acc_n_s    = {ACC_W{1'b0}};
                    max_n_s    = {SUM_W{1'b0}};
                    state_n_s  = HOLD;
                end else begin
                    cnt_inc_s = accept_s;
                    acc_n_s   = beat_acc_s;
                    max_n_s   = beat_max_s;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n_s = ACCUM;
                    if (in_valid) begin
                        acc_n_s   = s_ext_s;
                        max_n_s   = S;
                        cnt_clr_s = 1'b1;
                        cnt_inc_s = 1'b1;
                    end else begin
                        acc_n_s = acc_r;
                        max_n_s = max_r;
                    end
                end else begin
                    state_n_s = HOLD;
                end
            end
            default: begin
                state_n_s = ACCUM;
                acc_n_s   = {ACC_W{1'b0}};
                max_n_s   = {SUM_W{1'b0}};
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ACCUM;
            acc_r       <= {ACC_W{1'b0}};
            max_r       <= {SUM_W{1'b0}};
            out_total_r <= {ACC_W{1'b0}};
            out_max_r   <= {SUM_W{1'b0}};
            out_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_n_s;
            acc_r   <= acc_n_s;
            max_r   <= max_n_s;
            if (load_out_s) begin
                out_total_r <= beat_acc_s;
                out_max_r   <= beat_max_s;
                out_count_r <= beat_cnt_s;
            end else begin
                out_total_r <= out_total_r;
                out_max_r   <= out_max_r;
                out_count_r <= out_count_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == HOLD);
    assign out_total = out_total_r;
    assign out_max   = out_max_r;
    assign out_count = out_count_r;

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Directed and randomized bench for sum_window_accumulator against a window-list
// reference model (queue of samples per window).
module tb_sum_window_accumulator;

    localparam int COUNT = 8;
    localparam int CNT_W = 4;
    localparam int ACC_W = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       S = 4'd0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_total;
    logic [3:0]       out_max;
    logic [CNT_W-1:0] out_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int m_win[$];
    bit m_hold = 1'b0;
    int m_total = 0;
    int m_max = 0;
    int m_count = 0;
    int n_acc = 0;
    longint sum_in = 0;
    longint sum_out = 0;

    sum_window_accumulator #(.COUNT(COUNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_total (out_total),
        .out_max   (out_max),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit v, input int s, input bit f, input bit ordy, input bit r);
        if (r) begin
            m_hold = 1'b0;
            m_win.delete();
            m_total = 0;
            m_max = 0;
            m_count = 0;
        end else if (!m_hold) begin
            if (v) begin
                m_win.push_back(s);
                sum_in += s;
                n_acc++;
            end
            if ((v && m_win.size() == COUNT) || (f && m_win.size() != 0)) begin
                m_total = 0;
                m_max = 0;
                foreach (m_win[i]) begin
                    m_total += m_win[i];
                    if (m_win[i] > m_max) m_max = m_win[i];
                end
                m_count = m_win.size();
                m_win.delete();
                m_hold = 1'b1;
            end
        end else if (ordy) begin
            m_hold = 1'b0;
            if (v) begin
                m_win.push_back(s);
                sum_in += s;
                n_acc++;
            end
        end
    endtask

    // Apply one cycle of inputs, compare outputs mid-cycle, advance the model.
    task automatic step(input bit v, input int s, input bit f, input bit ordy, input bit r);
        in_valid  = v;
        S         = 4'(s);
        flush     = f;
        out_ready = ordy;
        rst       = r;
        @(negedge clk);
        check("in_ready",  {31'd0, in_ready},  {31'd0, (!m_hold || ordy)});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
        check("out_total", 32'(out_total), 32'(m_total));
        check("out_max",   32'(out_max),   32'(m_max));
        check("out_count", 32'(out_count), 32'(m_count));
        if (out_valid && ordy && !r) sum_out += out_total;
        model_update(v, s, f, ordy, r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int cyc;

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_total", 32'(out_total), 32'd0);

        // 1: full window of maximum adder sums
        for (int i = 0; i < 8; i++) step(1, 14, 0, 1, 0);
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_total", 32'(out_total), 32'd112);
        check("t1_max",   32'(out_max),   32'd14);
        check("t1_count", 32'(out_count), 32'd8);
        step(0, 0, 0, 1, 0);

        // 2: early flush, then flush on an empty window
        step(1, 1, 0, 1, 0);
        step(1, 2, 0, 1, 0);
        step(1, 3, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        check("t2_total", 32'(out_total), 32'd6);
        check("t2_max",   32'(out_max),   32'd3);
        check("t2_count", 32'(out_count), 32'd3);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        check("t2_empty_flush", {31'd0, out_valid}, 32'd0);

        // 3: flush coincident with the COUNT-th beat
        for (int i = 0; i < 7; i++) step(1, 5, 0, 1, 0);
        step(1, 9, 1, 1, 0);
        check("t3_total", 32'(out_total), 32'd44);
        check("t3_max",   32'(out_max),   32'd9);
        check("t3_count", 32'(out_count), 32'd8);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        check("t3_single", {31'd0, out_valid}, 32'd0);

        // 4: backpressure in HOLD, then take with same-cycle beat
        for (int i = 0; i < 8; i++) step(1, 2, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 3, 0, 0, 0);
        check("t4_ready", {31'd0, in_ready}, 32'd0);
        check("t4_total", 32'(out_total), 32'd16);
        step(1, 7, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 1, 0);
        check("t4_new_total", 32'(out_total), 32'd14);
        check("t4_new_max",   32'(out_max),   32'd7);
        check("t4_new_count", 32'(out_count), 32'd8);
        step(0, 0, 0, 1, 0);

        // 5: random throttling and early flushes
        sum_in = 0;
        sum_out = 0;
        base = n_acc;
        cyc = 0;
        while ((n_acc - base) < 1000 && cyc < 20000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, 0);
            cyc++;
        end
        check("t5_beats_done", {31'd0, (n_acc - base) >= 1000}, 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
        check("t5_sum", 32'(sum_out), 32'(sum_in));

        // 6: reset mid-window and during HOLD
        for (int i = 0; i < 4; i++) step(1, 3, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        check("t6_rst_count", 32'(out_count), 32'd0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
        check("t6_total_a", 32'(out_total), 32'd8);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("t6_hold_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_hold_rst_total", 32'(out_total), 32'd0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 0);
        check("t6_total_b", 32'(out_total), 32'd8);
        check("t6_count_b", 32'(out_count), 32'd8);
        step(0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
